// File: rtl/pipeline_muldiv.sv
// pipeline_muldiv
// Iterative multiply/divide stage that sits beside the ALU stage and owns
// the HI/LO register pair. MULT/MULTU/DIV/DIVU run for W/BPC cycles, retiring
// BPC bits per cycle. MFHI/MFLO/MTHI/MTLO are served in one edge when idle.
// Issue is held off through the combinational stall output while an
// iterative op is running.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   valid_in        op_in and operands are valid this cycle
//   op_in           0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                   5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 illegal
//   rs_val, rt_val  operand A / operand B
//   rd_index_in     destination register for MFHI/MFLO
//   flush           abort the running op and drop this cycle's op
//   stall           op not accepted this cycle, issue must hold inputs
//   busy            iterative op in progress
//   rd_index        writeback index, 0 = no write
//   rd_value        writeback value
//   exception       3'b001 for one cycle after an illegal op is accepted
module pipeline_muldiv #(
  parameter int W   = 32,
  parameter int BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic [3:0]   op_in,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic [4:0]   rd_index_in,
  input  logic         flush,
  output logic         stall,
  output logic         busy,
  output logic [4:0]   rd_index,
  output logic [W-1:0] rd_value,
  output logic [2:0]   exception
);

  localparam int STEPS = W / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic [W-1:0]  hi, lo;
  logic [CW-1:0] cnt;
  logic [W-1:0]  m_reg;
  logic [W-1:0]  acc_hi, acc_lo;
  logic [W-1:0]  a_raw;
  logic          is_div, neg_q, neg_r, div_zero;

  logic          op_iter, op_legal, accept, last_step;
  logic          signed_op, a_neg, b_neg;
  logic [W-1:0]  a_mag, b_mag;

  logic [W-1:0]  step_hi, step_lo;
  logic [W:0]    sum, trial;
  logic [2*W-1:0] prod;
  logic [W-1:0]  quo, rem, res_hi, res_lo;

  // Decode, handshake and the edge on which the last bits retire.
  always_comb begin
    op_iter   = (op_in >= OP_MULT) && (op_in <= OP_DIVU);
    op_legal  = (op_in <= OP_MTLO);
    stall     = valid_in && busy && !flush && (op_in != OP_NOP) && op_legal;
    accept    = valid_in && !stall && !flush;
    last_step = (state == RUN) && (cnt == CW'(1));
  end

  // Sign-corrected magnitudes; the sign is reapplied once the unsigned
  // iteration finishes. The most-negative value still fits as an unsigned
  // magnitude, which is what makes MIN / -1 come out as MIN with rem 0.
  always_comb begin
    signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    a_neg     = signed_op && rs_val[W-1];
    b_neg     = signed_op && rt_val[W-1];
    a_mag     = a_neg ? -rs_val : rs_val;
    b_mag     = b_neg ? -rt_val : rt_val;
  end

  // One cycle worth of iteration. Multiply keeps the partial product in
  // acc_hi and shifts the multiplier out of acc_lo; divide shifts the
  // dividend from acc_lo into the remainder in acc_hi while quotient bits
  // fill acc_lo from the bottom. A divisor of zero just produces an
  // all-ones quotient here and is overridden in the result logic.
  always_comb begin
    step_hi = acc_hi;
    step_lo = acc_lo;
    sum     = '0;
    trial   = '0;
    for (int i = 0; i < BPC; i++) begin
      if (is_div) begin
        trial = {step_hi, step_lo[W-1]} - {1'b0, m_reg};
        if (!trial[W]) begin
          step_hi = trial[W-1:0];
        end else begin
          step_hi = {step_hi[W-2:0], step_lo[W-1]};
        end
        step_lo = {step_lo[W-2:0], !trial[W]};
      end else begin
        sum     = {1'b0, step_hi} + (step_lo[0] ? {1'b0, m_reg} : '0);
        step_hi = sum[W:1];
        step_lo = {sum[0], step_lo[W-1:1]};
      end
    end
  end

  // Final HI/LO from the last iteration's values, with signs restored.
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_q) begin
      prod = -prod;
    end
    quo = neg_q ? -step_lo : step_lo;
    rem = neg_r ? -step_hi : step_hi;
    if (!is_div) begin
      res_hi = prod[2*W-1:W];
      res_lo = prod[W-1:0];
    end else if (div_zero) begin
      res_hi = a_raw;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: flush beats completion.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && op_iter) state_nxt = RUN;
      RUN:  if (flush || last_step) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs derived from state.
  always_comb begin
    busy = (state == RUN);
  end

  // Datapath, HI/LO and the one-cycle writeback/exception pulses. A flush
  // only clears the counter; HI/LO keep whatever they held before the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      m_reg     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      a_raw     <= '0;
      is_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      rd_index  <= '0;
      rd_value  <= '0;
      exception <= '0;
    end else begin
      rd_index  <= '0;
      rd_value  <= '0;
      exception <= '0;
      if (flush) begin
        cnt <= '0;
      end else begin
        if (state == RUN) begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
          if (last_step) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        if (accept) begin
          case (op_in)
            OP_NOP: ;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div   <= (op_in == OP_DIV) || (op_in == OP_DIVU);
              neg_q    <= a_neg ^ b_neg;
              neg_r    <= (op_in == OP_DIV) && rs_val[W-1];
              div_zero <= (rt_val == '0);
              a_raw    <= rs_val;
              acc_hi   <= '0;
              cnt      <= CW'(STEPS);
              if ((op_in == OP_DIV) || (op_in == OP_DIVU)) begin
                m_reg  <= b_mag;
                acc_lo <= a_mag;
              end else begin
                m_reg  <= a_mag;
                acc_lo <= b_mag;
              end
            end
            OP_MFHI: begin
              rd_index <= rd_index_in;
              rd_value <= hi;
            end
            OP_MFLO: begin
              rd_index <= rd_index_in;
              rd_value <= lo;
            end
            OP_MTHI: hi <= rs_val;
            OP_MTLO: lo <= rs_val;
            default: exception <= 3'b001;
          endcase
        end
      end
    end
  end

endmodule
